// File: rtl/pitch_detector_if.sv
// Sample-in / pitch-out bundle between a waveform source and pitch_detector.
interface pitch_detector_if #(
  parameter int unsigned VOLT_W = 16,
  parameter int unsigned KEY_W  = 7
) ();
  logic signed [VOLT_W-1:0] v;
  logic        [KEY_W-1:0]  key;
  logic                     key_valid;
  logic                     locked;

  // Source side drives samples and observes the detected pitch.
  modport master (output v, input key, input key_valid, input locked);
  // Detector side consumes samples and reports the pitch.
  modport slave  (input v, output key, output key_valid, output locked);
endinterface

// File: rtl/pitch_detector.sv
// Measures the period of an incoming waveform over NAVG cycles and reports the
// oscillator key whose phase step best reproduces it.
module pitch_detector #(
  parameter int unsigned VOLT_W     = 16,
  parameter int unsigned KEY_W      = 7,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned NAVG       = 4,
  parameter int unsigned HYST       = 256,
  parameter int unsigned MIN_PERIOD = 64,
  parameter int unsigned MAX_PERIOD = 4095
) (
  input  logic            clk,
  input  logic            rst_n,
  pitch_detector_if.slave bus
);

  localparam int unsigned PERIOD_W = $clog2(MAX_PERIOD + 1);
  localparam int unsigned NAVG_W   = $clog2(NAVG);
  localparam int unsigned S_W      = PERIOD_W + NAVG_W;
  localparam int unsigned STEP_W   = 10;
  localparam int unsigned PROD_W   = S_W + STEP_W;
  localparam int unsigned N_W      = NAVG_W + 1;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned KEY_LO   = 25;
  localparam int unsigned KEY_HI   = 76;
  localparam int unsigned N_KEYS   = KEY_HI - KEY_LO + 1;

  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(N_KEYS - 1);
  localparam logic [PROD_W-1:0]          TARGET   = PROD_W'(1) << (ACC_W + NAVG_W);
  localparam logic signed [VOLT_W-1:0]   HYST_P   = VOLT_W'(HYST);
  localparam logic signed [VOLT_W-1:0]   HYST_N   = -HYST_P;
  localparam logic [PERIOD_W-1:0]        PCNT_MIN = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]        PCNT_MAX = PERIOD_W'(MAX_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_MEASURE,
    S_SEARCH,
    S_PUBLISH
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic signed [VOLT_W-1:0]  w_v;
  logic                      w_below;
  logic                      w_above;
  logic                      w_cross;
  logic                      r_armed;

  logic [PERIOD_W-1:0]       r_pcnt;
  logic [S_W-1:0]            r_sum;
  logic [N_W-1:0]            r_n;
  logic [IDX_W-1:0]          r_idx;
  logic [PROD_W-1:0]         r_best_err;
  logic [KEY_W-1:0]          r_best_key;

  logic [KEY_W-1:0]          r_key;
  logic                      r_key_valid;
  logic                      r_locked;

  logic                      w_start;
  logic                      w_accept;
  logic                      w_timeout;
  logic                      w_publish;
  logic                      w_pcnt_last;
  logic [STEP_W-1:0]         w_step;
  logic [PROD_W-1:0]         w_prod;
  logic [PROD_W-1:0]         w_err;
  logic [KEY_W-1:0]          w_cand_key;

  // Oscillator key->phase-step table, indexed by key-25.
  function automatic logic [STEP_W-1:0] step_of(input logic [IDX_W-1:0] idx);
    logic [STEP_W-1:0] s;
    case (idx)
      6'd0:  s = 10'd22;
      6'd1:  s = 10'd23;
      6'd2:  s = 10'd25;
      6'd3:  s = 10'd26;
      6'd4:  s = 10'd28;
      6'd5:  s = 10'd30;
      6'd6:  s = 10'd31;
      6'd7:  s = 10'd33;
      6'd8:  s = 10'd35;
      6'd9:  s = 10'd37;
      6'd10: s = 10'd40;
      6'd11: s = 10'd42;
      6'd12: s = 10'd45;
      6'd13: s = 10'd47;
      6'd14: s = 10'd50;
      6'd15: s = 10'd53;
      6'd16: s = 10'd56;
      6'd17: s = 10'd60;
      6'd18: s = 10'd63;
      6'd19: s = 10'd67;
      6'd20: s = 10'd71;
      6'd21: s = 10'd75;
      6'd22: s = 10'd80;
      6'd23: s = 10'd85;
      6'd24: s = 10'd90;
      6'd25: s = 10'd95;
      6'd26: s = 10'd101;
      6'd27: s = 10'd107;
      6'd28: s = 10'd113;
      6'd29: s = 10'd120;
      6'd30: s = 10'd127;
      6'd31: s = 10'd135;
      6'd32: s = 10'd143;
      6'd33: s = 10'd151;
      6'd34: s = 10'd160;
      6'd35: s = 10'd170;
      6'd36: s = 10'd180;
      6'd37: s = 10'd190;
      6'd38: s = 10'd202;
      6'd39: s = 10'd214;
      6'd40: s = 10'd227;
      6'd41: s = 10'd240;
      6'd42: s = 10'd254;
      6'd43: s = 10'd270;
      6'd44: s = 10'd286;
      6'd45: s = 10'd303;
      6'd46: s = 10'd321;
      6'd47: s = 10'd340;
      6'd48: s = 10'd360;
      6'd49: s = 10'd381;
      6'd50: s = 10'd404;
      6'd51: s = 10'd428;
      default: s = 10'd0;
    endcase
    return s;
  endfunction

  // Hysteretic rising-crossing detector: arm below -HYST, fire at +HYST.
  assign w_v     = bus.v;
  assign w_below = (w_v < HYST_N);
  assign w_above = (w_v >= HYST_P);
  assign w_cross = r_armed & w_above;

  // Arming flag; a crossing consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (w_cross) begin
      r_armed <= 1'b0;
    end else if (w_below) begin
      r_armed <= 1'b1;
    end
  end

  // Candidate error for the table entry under scan this clock.
  assign w_step      = step_of(r_idx);
  assign w_prod      = PROD_W'(r_sum) * PROD_W'(w_step);
  assign w_err       = (w_prod >= TARGET) ? (w_prod - TARGET) : (TARGET - w_prod);
  assign w_cand_key  = KEY_W'(KEY_LO) + KEY_W'(r_idx);
  assign w_pcnt_last = (r_pcnt >= (PCNT_MAX - PERIOD_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_publish   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_armed) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_cross) begin
          w_start     = 1'b1;
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // A period that would reach MAX_PERIOD means the signal is gone.
        if (w_pcnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cross && (r_pcnt >= PCNT_MIN)) begin
          w_accept = 1'b1;
          if (r_n == N_W'(NAVG - 1)) w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (r_idx == LAST_IDX) w_state_nxt = S_PUBLISH;
      end
      S_PUBLISH: begin
        w_publish   = 1'b1;
        w_state_nxt = S_ARMED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Period counting, window sum and nearest-step scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt     <= '0;
      r_sum      <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_best_err <= '0;
      r_best_key <= '0;
    end else begin
      if (w_start || w_accept) begin
        r_pcnt <= '0;
      end else if ((r_state == S_MEASURE) && (r_pcnt != PCNT_MAX)) begin
        r_pcnt <= r_pcnt + PERIOD_W'(1);
      end

      if (w_start) begin
        r_sum <= '0;
        r_n   <= '0;
      end else if (w_accept) begin
        r_sum <= r_sum + S_W'(r_pcnt) + S_W'(1);
        r_n   <= r_n + N_W'(1);
      end

      if (r_state == S_SEARCH) begin
        r_idx <= r_idx + IDX_W'(1);
        // Strict compare keeps the lower key on a tie.
        if ((r_idx == '0) || (w_err < r_best_err)) begin
          r_best_err <= w_err;
          r_best_key <= w_cand_key;
        end
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Published key, one-cycle valid pulse and lock status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_key_valid <= w_publish;
      if (w_publish) begin
        r_key    <= r_best_key;
        r_locked <= 1'b1;
      end else if (w_timeout) begin
        r_key    <= '0;
        r_locked <= 1'b0;
      end
    end
  end

  assign bus.key       = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.locked    = r_locked;

endmodule

// File: tb/tb_pitch_detector.sv
// Directed bench: a square-wave phase-accumulator source drives pitch_detector
// and the published key, lock and timing are compared to hand-derived values.
module tb_pitch_detector;

  localparam int unsigned VOLT_W = 16;
  localparam int unsigned KEY_W  = 7;
  localparam int HYST = 256;
  localparam int AMP  = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pitch_detector_if #(.VOLT_W(VOLT_W), .KEY_W(KEY_W)) dut_if ();

  pitch_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int kv_cnt = 0;
  int kv_key = -1;
  int kv_lat = -1;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int mode = 2;               // 0 = oscillator, 1 = small noise, 2 = flat
  logic [15:0] phase = '0;
  logic [15:0] step  = '0;
  bit b_armed    = 1'b0;
  bit saw_unlock = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive the next sample.
  task automatic tick();
    int nv;
    @(posedge clk);
    cyc++;
    #1;
    if (dut_if.key_valid === 1'b1) begin
      kv_cnt++;
      kv_key = int'(dut_if.key);
      kv_lat = cyc - rise_cyc;
    end
    if (dut_if.locked !== 1'b1) saw_unlock = 1'b1;
    case (mode)
      0: begin
        phase = phase + step;
        nv = phase[15] ? -AMP : AMP;
      end
      1: nv = int'($urandom_range(200)) - 100;
      default: nv = 0;
    endcase
    if (nv < -HYST) begin
      b_armed = 1'b1;
    end else if (b_armed && nv >= HYST) begin
      b_armed  = 1'b0;
      rise_cnt++;
      rise_cyc = cyc + 1;
    end
    dut_if.v = VOLT_W'(nv);
  endtask

  task automatic wait_kv(input int target, input int budget, input string tag);
    int n = 0;
    while (kv_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(kv_cnt >= target), 1);
  endtask

  task automatic wait_rises(input int target, input int budget, input string tag);
    int n = 0;
    while (rise_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(rise_cnt >= target), 1);
  endtask

  initial begin
    int base;
    dut_if.v = '0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_key", int'(dut_if.key), 0);
    chk("reset_valid", int'(dut_if.key_valid), 0);
    chk("reset_locked", int'(dut_if.locked), 0);
    rst_n = 1'b1;

    // Noise inside the hysteresis band never triggers.
    mode = 1;
    repeat (3000) tick();
    chk("noise_no_valid", kv_cnt, 0);
    chk("noise_key", int'(dut_if.key), 0);
    chk("noise_locked", int'(dut_if.locked), 0);

    // Key 49: step 90, ~728-clock period.
    mode  = 0;
    phase = '0;
    step  = 16'd90;
    wait_kv(1, 8000, "k49_publish");
    chk("k49_key", kv_key, 49);
    chk("k49_locked", int'(dut_if.locked), 1);
    chk("k49_latency", kv_lat, 53);
    tick();
    chk("k49_pulse_width", int'(dut_if.key_valid), 0);
    chk("k49_key_hold", int'(dut_if.key), 49);

    // Retune to key 60 while locked.
    saw_unlock = 1'b0;
    step = 16'd170;
    base = kv_cnt;
    wait_kv(base + 2, 12000, "k60_publish");
    chk("k60_key", int'(dut_if.key), 60);
    chk("k60_lock_held", int'(saw_unlock), 0);

    // Table boundaries.
    step = 16'd22;
    base = kv_cnt;
    wait_kv(base + 2, 40000, "k25_publish");
    chk("k25_key", kv_key, 25);
    step = 16'd428;
    base = kv_cnt;
    wait_kv(base + 2, 4000, "k76_publish");
    chk("k76_key", kv_key, 76);

    // Back to 49, then reset in the middle of a scan.
    step = 16'd90;
    base = kv_cnt;
    wait_kv(base + 2, 12000, "relock49_publish");
    chk("relock49_key", int'(dut_if.key), 49);
    base = rise_cnt;
    wait_rises(base + 5, 5000, "search_entry_rises");
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_key", int'(dut_if.key), 0);
    chk("async_rst_valid", int'(dut_if.key_valid), 0);
    chk("async_rst_locked", int'(dut_if.locked), 0);
    base = kv_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_abort_no_publish", kv_cnt, base);
    wait_kv(base + 1, 8000, "restart_publish");
    chk("restart_key", kv_key, 49);
    chk("restart_locked", int'(dut_if.locked), 1);

    // Signal goes flat mid-measurement: timeout MAX_PERIOD clocks after last crossing.
    base = rise_cnt;
    wait_rises(base + 2, 3000, "pre_flat_rises");
    mode = 2;
    base = kv_cnt;
    while (cyc < rise_cyc + 4093) tick();
    chk("flat_before_timeout_locked", int'(dut_if.locked), 1);
    repeat (4) tick();
    chk("flat_timeout_locked", int'(dut_if.locked), 0);
    chk("flat_timeout_key", int'(dut_if.key), 0);
    chk("flat_timeout_no_valid", kv_cnt, base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
